id_issue_queue: RTL and testbench

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

---
 rtl/id_issue_queue.sv | 172 +++++++++++++++++
 tb/tb_id_issue_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// id_issue_queue: decode-stage instruction buffer with operand resolution.
// Fetched {pc, inst} pairs are held in a circular buffer. The head entry reads
// the register file, resolves its operands through the forwarding network and
// is issued into a registered valid/ready output stage. A head that depends on
// an in-flight load is held back and reported on stallreq.
module id_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int FWD_PORTS = 3,
    parameter int LW        = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    if_valid,
    output logic                    if_ready,
    input  logic [31:0]             if_pc,
    input  logic [31:0]             if_inst,
    output logic [4:0]              rf_raddr1,
    output logic [4:0]              rf_raddr2,
    input  logic [31:0]             rf_rdata1,
    input  logic [31:0]             rf_rdata2,
    input  logic [FWD_PORTS*38-1:0] fwd_bus,
    input  logic                    ex_load,
    input  logic [4:0]              ex_load_waddr,
    output logic                    id_valid,
    input  logic                    id_ready,
    output logic [31:0]             id_pc,
    output logic [31:0]             id_inst,
    output logic [31:0]             id_rdata1,
    output logic [31:0]             id_rdata2,
    output logic                    stallreq,
    output logic [LW-1:0]           level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra pointer bit distinguishes full from empty.
    localparam int PW = AW + 1;

    // Register number 0 is hardwired to zero; forwarding slices are searched
    // from the lowest index, so walking downward leaves the lowest hit last.
    function automatic logic [31:0] resolve_operand(
        input logic [4:0]              addr,
        input logic [31:0]             rf_data,
        input logic [FWD_PORTS*38-1:0] bus
    );
        logic [31:0] result;
        logic [37:0] slice;
        result = rf_data;
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            slice = bus[i*38 +: 38];
            if (slice[37] && (slice[36:32] != 5'd0) && (slice[36:32] == addr)) begin
                result = slice[31:0];
            end
        end
        if (addr == 5'd0) begin
            result = 32'd0;
        end
        return result;
    endfunction

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_pc_q, id_pc_d;
    logic [31:0]   id_inst_q, id_inst_d;
    logic [31:0]   id_rdata1_q, id_rdata1_d;
    logic [31:0]   id_rdata2_q, id_rdata2_d;

    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic [31:0]   head_pc;
    logic [31:0]   head_inst;
    logic [4:0]    head_rs;
    logic [4:0]    head_rt;
    logic          load_use;
    logic          issuable;
    logic          push;
    logic          issue;
    logic          mem_we;

    // Occupancy, head decode and the load-use hazard on the head entry.
    always_comb begin
        count     = wr_ptr_q - rd_ptr_q;
        full      = (count == PW'(DEPTH));
        empty     = (count == '0);
        head_pc   = pc_mem_q[rd_ptr_q[AW-1:0]];
        head_inst = inst_mem_q[rd_ptr_q[AW-1:0]];
        head_rs   = head_inst[25:21];
        head_rt   = head_inst[20:16];
        load_use  = ~empty & ex_load & (ex_load_waddr != 5'd0) &
                    ((ex_load_waddr == head_rs) | (ex_load_waddr == head_rt));
        issuable  = ~empty & ~load_use;
        push      = if_valid & ~full;
        issue     = issuable & (~id_valid_q | id_ready);
        mem_we    = push & ~flush;
    end

    // Pointer and output-stage next state; flush overrides push and issue.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_rdata1_d = id_rdata1_q;
        id_rdata2_d = id_rdata2_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            id_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (issue) begin
                rd_ptr_d    = rd_ptr_q + PW'(1);
                id_valid_d  = 1'b1;
                id_pc_d     = head_pc;
                id_inst_d   = head_inst;
                id_rdata1_d = resolve_operand(head_rs, rf_rdata1, fwd_bus);
                id_rdata2_d = resolve_operand(head_rt, rf_rdata2, fwd_bus);
            end else if (id_valid_q & id_ready) begin
                id_valid_d = 1'b0;
            end
        end
    end

    // Control and output-stage registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_inst_q   <= '0;
            id_rdata1_q <= '0;
            id_rdata2_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_rdata1_q <= id_rdata1_d;
            id_rdata2_q <= id_rdata2_d;
        end
    end

    // Buffer storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            pc_mem_q[wr_ptr_q[AW-1:0]]   <= if_pc;
            inst_mem_q[wr_ptr_q[AW-1:0]] <= if_inst;
        end
    end

    assign if_ready  = ~full;
    assign rf_raddr1 = head_rs;
    assign rf_raddr2 = head_rt;
    assign stallreq  = load_use;
    assign level     = LW'(count);
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign id_rdata1 = id_rdata1_q;
    assign id_rdata2 = id_rdata2_q;

endmodule

// File: tb/tb_id_issue_queue.sv
// Testbench for id_issue_queue: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
module tb_id_issue_queue;

    localparam int DEPTH = 4;
    localparam int FWD   = 3;
    localparam int LW    = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic              clk;
    logic              resetn;
    logic              flush;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_pc;
    logic [31:0]       if_inst;
    logic [4:0]        rf_raddr1;
    logic [4:0]        rf_raddr2;
    logic [31:0]       rf_rdata1;
    logic [31:0]       rf_rdata2;
    logic [FWD*38-1:0] fwd_bus;
    logic              ex_load;
    logic [4:0]        ex_load_waddr;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_pc;
    logic [31:0]       id_inst;
    logic [31:0]       id_rdata1;
    logic [31:0]       id_rdata2;
    logic              stallreq;
    logic [LW-1:0]     level;

    logic [31:0] regs [32];
    logic [37:0] fs   [FWD];

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];
    assign fwd_bus   = {fs[2], fs[1], fs[0]};

    id_issue_queue #(.DEPTH(DEPTH), .FWD_PORTS(FWD), .LW(LW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_bus(fwd_bus), .ex_load(ex_load), .ex_load_waddr(ex_load_waddr),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .stallreq(stallreq), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    ent_t        mq [$];
    logic        m_vld;
    logic [31:0] m_pc, m_inst, m_r1, m_r2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Operand value by the architectural rule: $0 is zero, then the
    // lowest-indexed matching forwarding slice, then the register file.
    function automatic logic [31:0] mres(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        for (int i = 0; i < FWD; i++) begin
            if (fs[i][37] && fs[i][36:32] == a) return fs[i][31:0];
        end
        return regs[a];
    endfunction

    // One clock cycle with the inputs already driven: check combinational
    // outputs, advance the model, then check registered outputs.
    task automatic step();
        ent_t h;
        logic lu, full, iss;
        #1;
        full = (mq.size() == DEPTH);
        lu   = 1'b0;
        if (mq.size() > 0) begin
            h  = mq[0];
            lu = ex_load && (ex_load_waddr != 5'd0) &&
                 (ex_load_waddr == h.inst[25:21] || ex_load_waddr == h.inst[20:16]);
            chk("rf_raddr1", 32'(rf_raddr1), 32'(h.inst[25:21]));
            chk("rf_raddr2", 32'(rf_raddr2), 32'(h.inst[20:16]));
        end
        chk("stallreq", 32'(stallreq), 32'(lu));
        chk("if_ready_pre", 32'(if_ready), 32'(!full));
        if (flush) begin
            mq.delete();
            m_vld = 1'b0;
        end else begin
            iss = (mq.size() > 0) && !lu && (!m_vld || id_ready);
            if (iss) begin
                m_vld  = 1'b1;
                m_pc   = h.pc;
                m_inst = h.inst;
                m_r1   = mres(h.inst[25:21]);
                m_r2   = mres(h.inst[20:16]);
                void'(mq.pop_front());
            end else if (m_vld && id_ready) begin
                m_vld = 1'b0;
            end
            if (if_valid && !full) mq.push_back('{if_pc, if_inst});
        end
        @(posedge clk);
        @(negedge clk);
        chk("id_valid", 32'(id_valid), 32'(m_vld));
        chk("level", 32'(level), 32'(mq.size()));
        chk("if_ready", 32'(if_ready), 32'(mq.size() != DEPTH));
        if (m_vld) begin
            chk("id_pc", id_pc, m_pc);
            chk("id_inst", id_inst, m_inst);
            chk("id_rdata1", id_rdata1, m_r1);
            chk("id_rdata2", id_rdata2, m_r2);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        mq.delete();
        m_vld = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
        ex_load = 1'b0; ex_load_waddr = '0; id_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < FWD; i++) fs[i] = '0;
        m_vld = 1'b0; m_pc = '0; m_inst = '0; m_r1 = '0; m_r2 = '0;

        // Reset state.
        #12;
        chk("reset_id_valid", 32'(id_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_if_ready", 32'(if_ready), 32'd1);
        chk("reset_stallreq", 32'(stallreq), 32'd0);
        chk("reset_id_pc", id_pc, 32'd0);
        chk("reset_id_inst", id_inst, 32'd0);
        chk("reset_id_rdata1", id_rdata1, 32'd0);
        chk("reset_id_rdata2", id_rdata2, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single instruction stream: addu $3,$1,$2.
        regs[1] = 32'd5; regs[2] = 32'd7;
        if_valid = 1'b1; if_pc = 32'hBFC0_0000; if_inst = 32'h0022_1821;
        step();
        chk("lat_first_edge", 32'(id_valid), 32'd0);
        if_valid = 1'b0;
        step();
        chk("addu_valid", 32'(id_valid), 32'd1);
        chk("addu_pc", id_pc, 32'hBFC0_0000);
        chk("addu_rs", id_rdata1, 32'd5);
        chk("addu_rt", id_rdata2, 32'd7);
        step();

        // Forwarding priority.
        fs[0] = {1'b1, 5'd1, 32'h11};
        fs[1] = {1'b1, 5'd1, 32'h22};
        regs[1] = 32'h33;
        if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h0020_1821;
        step();
        if_valid = 1'b0;
        step();
        chk("fwd_slice0", id_rdata1, 32'h11);
        fs[0] = {1'b1, 5'd0, 32'h44};
        if_valid = 1'b1; if_pc = 32'h104; if_inst = 32'h0001_1821;
        step();
        if_valid = 1'b0;
        step();
        chk("fwd_rs_zero", id_rdata1, 32'd0);
        chk("fwd_waddr0_ignored", id_rdata2, 32'h22);
        for (int i = 0; i < FWD; i++) fs[i] = '0;

        // Load-use hazard on rt.
        if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h0000_0000;
        step();
        if_pc = 32'h204; if_inst = 32'h00A4_1821;
        step();
        if_valid = 1'b0; ex_load = 1'b1; ex_load_waddr = 5'd4;
        step();
        chk("lu_stallreq", 32'(stallreq), 32'd1);
        chk("lu_no_pop", 32'(level), 32'd1);
        chk("lu_valid_drop", 32'(id_valid), 32'd0);
        step();
        ex_load = 1'b0;
        step();
        chk("lu_issue_pc", id_pc, 32'h204);
        step();

        // Full queue under backpressure, then drain across the pointer wrap.
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if_valid = 1'b1; if_pc = 32'h1000 + 32'(i * 4);
            if_inst = {6'd0, 5'(i + 1), 5'(i + 2), 16'h1821};
            step();
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_if_ready", 32'(if_ready), 32'd0);
        chk("full_pc_stable", id_pc, 32'h1000);
        if_valid = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("drain_level", 32'(level), 32'd0);

        // Flush with a loaded queue and a simultaneous fetch.
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_pc = 32'h2000 + 32'(i * 4); if_inst = 32'h0043_1821;
            step();
        end
        chk("preflush_level", 32'(level), 32'd3);
        chk("preflush_valid", 32'(id_valid), 32'd1);
        flush = 1'b1; if_pc = 32'h2100;
        step();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_if_ready", 32'(if_ready), 32'd1);
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("flush_dropped", 32'(id_valid), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            flush         = ($urandom_range(0, 19) == 0);
            if_valid      = ($urandom_range(0, 3) != 0);
            if_pc         = $urandom;
            if_inst       = {6'($urandom), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 16'($urandom)};
            id_ready      = ($urandom_range(0, 9) < 7);
            ex_load       = ($urandom_range(0, 3) == 0);
            ex_load_waddr = 5'($urandom_range(0, 7));
            for (int i = 0; i < FWD; i++)
                fs[i] = {1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(1, 7)] = $urandom;
            step();
        end

        // Asynchronous reset with entries buffered, then a fresh push.
        flush = 1'b0; ex_load = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < FWD; i++) fs[i] = '0;
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_pc = 32'h3000 + 32'(i * 4); if_inst = 32'h0022_1821;
            step();
        end
        if_valid = 1'b0;
        async_reset();
        id_ready = 1'b1;
        if_valid = 1'b1; if_pc = 32'h4000; if_inst = 32'h0022_1821;
        step();
        chk("post_rst_lat", 32'(id_valid), 32'd0);
        if_valid = 1'b0;
        step();
        chk("post_rst_pc", id_pc, 32'h4000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
